hwpe_stream_tcdm_fifo_store_batch: RTL and testbench

Parametrised store-side TCDM FIFO that decouples an HWPE store streamer from the TCDM interconnect. Data, address and byte-enable widths and queue depth are parametrised, and non-power-of-2 depths are supported. It adds occupancy and watermark flags, a wen-protocol error flag, and an optional batch mode that holds master requests until a programmable number of stores has accumulated or a flush is requested. It sits between the streamer's store port and the TCDM master port of the HWPE.

---
 rtl/hwpe_stream_tcdm_fifo_store_batch_if.sv | 16 +
 rtl/hwpe_stream_tcdm_fifo_store_batch.sv | 116 +++++++++++
 tb/tb_hwpe_stream_tcdm_fifo_store_batch.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_tcdm_fifo_store_batch_if.sv
// TCDM store-port bundle shared by the streamer side and the interconnect side.
// Handshake: a transfer happens on every clock edge where req && gnt; a raised req keeps its payload stable until granted.
interface hwpe_stream_tcdm_fifo_store_batch_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                    req;
    logic                    gnt;
    logic [ADDR_WIDTH-1:0]   add;
    logic                    wen;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   data;

    modport master (output req, add, wen, be, data, input gnt);
    modport slave  (input req, add, wen, be, data, output gnt);
endinterface

// File: rtl/hwpe_stream_tcdm_fifo_store_batch.sv
// Store-side TCDM FIFO with occupancy flags, sticky wen error and an optional
// batch mode that holds master requests until a threshold or flush releases them.
module hwpe_stream_tcdm_fifo_store_batch #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AF_MARGIN  = 2,
    localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       clear_i,
    input  logic                                       batch_en_i,
    input  logic [CW-1:0]                              release_thresh_i,
    input  logic                                       flush_i,
    hwpe_stream_tcdm_fifo_store_batch_if.slave         slv,
    hwpe_stream_tcdm_fifo_store_batch_if.master        mst,
    output logic [CW-1:0]                              count_o,
    output logic                                       empty_o,
    output logic                                       full_o,
    output logic                                       almost_full_o,
    output logic                                       err_o,
    output logic                                       dbg_state_o
);
    localparam int unsigned BW = DATA_WIDTH / 8;
    localparam int unsigned EW = BW + DATA_WIDTH + ADDR_WIDTH;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef enum logic {ACCUM = 1'b0, DRAIN = 1'b1} state_e;

    state_e          state_q;
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            err_q;
    logic            hold_q;
    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic [CW-1:0]   thresh_eff;
    logic [EW-1:0]   head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        thresh_eff = release_thresh_i;
        if (release_thresh_i > CW'(FIFO_DEPTH)) thresh_eff = CW'(FIFO_DEPTH);
        if (release_thresh_i == '0)             thresh_eff = CW'(1);
    end

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign slv.gnt = !full && !clear_i;
    assign push    = slv.req && slv.gnt;

    // hold_q keeps an ungranted request up even if batch_en_i toggles into ACCUM.
    assign mst.req = !empty && (!batch_en_i || (state_q == DRAIN) || hold_q);
    assign pop     = mst.req && mst.gnt;

    assign head = mem_q[rd_ptr_q];
    assign {mst.be, mst.data, mst.add} = empty ? '0 : head;
    assign mst.wen = 1'b0;

    assign count_o       = count_q;
    assign empty_o       = empty;
    assign full_o        = full;
    assign almost_full_o = (count_q >= CW'(FIFO_DEPTH - AF_MARGIN));
    assign err_o         = err_q;
    assign dbg_state_o   = (state_q == DRAIN);

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {slv.be, slv.data, slv.add};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ACCUM;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
        end else if (clear_i) begin
            state_q  <= ACCUM;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: ;
            endcase
            if (push && slv.wen) err_q <= 1'b1;
            hold_q <= mst.req && !mst.gnt;

            if (!batch_en_i) begin
                state_q <= ACCUM;
            end else begin
                case (state_q)
                    ACCUM: if ((count_q >= thresh_eff) || (flush_i && !empty)) state_q <= DRAIN;
                    DRAIN: if (pop && !push && (count_q == CW'(1)))           state_q <= ACCUM;
                    default: state_q <= ACCUM;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_hwpe_stream_tcdm_fifo_store_batch.sv
// Bench: depth-8 and depth-5 instances driven by shared stimulus, each checked every cycle against a queue model.
module tb_hwpe_stream_tcdm_fifo_store_batch;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst, clear, batch_en, flush, req, wen, mst_gnt;
    logic [3:0]    thresh;
    logic [AW-1:0] add;
    logic [DW-1:0] data;
    logic [3:0]    be;

    logic          o_gnt [2];
    logic          o_req [2];
    logic          o_wen [2];
    logic          o_empty [2];
    logic          o_full [2];
    logic          o_af [2];
    logic          o_err [2];
    logic          o_drain [2];
    logic [3:0]    o_count [2];
    logic [67:0]   o_head [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int D   = (g == 0) ? 8 : 5;
        localparam int CW  = $clog2(D + 1);
        localparam int AFM = 2;

        hwpe_stream_tcdm_fifo_store_batch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) slv_if ();
        hwpe_stream_tcdm_fifo_store_batch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mst_if ();
        logic [CW-1:0] cnt;

        assign slv_if.req  = req;
        assign slv_if.add  = add;
        assign slv_if.wen  = wen;
        assign slv_if.be   = be;
        assign slv_if.data = data;
        assign mst_if.gnt  = mst_gnt;

        hwpe_stream_tcdm_fifo_store_batch #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(D), .AF_MARGIN(AFM)
        ) dut (
            .clk_i(clk), .rst_i(rst), .clear_i(clear), .batch_en_i(batch_en),
            .release_thresh_i(thresh[CW-1:0]), .flush_i(flush),
            .slv(slv_if), .mst(mst_if),
            .count_o(cnt), .empty_o(o_empty[g]), .full_o(o_full[g]),
            .almost_full_o(o_af[g]), .err_o(o_err[g]), .dbg_state_o(o_drain[g])
        );

        assign o_gnt[g]   = slv_if.gnt;
        assign o_req[g]   = mst_if.req;
        assign o_wen[g]   = mst_if.wen;
        assign o_count[g] = 4'(cnt);
        assign o_head[g]  = {mst_if.be, mst_if.data, mst_if.add};

        // Reference model: queue of {be, data, add}, release flag, sticky error, pending-request flag.
        logic [67:0] q [$];
        bit drain = 0;
        bit err   = 0;
        bit pend  = 0;

        function automatic int thr_eff();
            int t;
            t = int'(thresh[CW-1:0]);
            if (t > D) t = D;
            if (t < 1) t = 1;
            return t;
        endfunction

        function automatic bit m_gnt();
            return (q.size() != D) && !clear;
        endfunction

        function automatic bit m_req();
            return (q.size() != 0) && (!batch_en || drain || pend);
        endfunction

        always @(posedge clk or posedge rst) begin
            if (rst || clear) begin
                q.delete();
                drain = 0;
                err   = 0;
                pend  = 0;
            end else begin
                bit pu, po, rq;
                int n;
                pu = req && m_gnt();
                rq = m_req();
                po = rq && mst_gnt;
                n  = q.size();
                if (!batch_en)  drain = 0;
                else if (!drain) begin
                    if (n >= thr_eff() || (flush && n != 0)) drain = 1;
                end else if (po && !pu && n == 1) drain = 0;
                pend = rq && !mst_gnt;
                if (po) void'(q.pop_front());
                if (pu) begin
                    q.push_back({be, data, add});
                    if (wen) err = 1;
                end
            end
        end

        always @(negedge clk) begin
            check($sformatf("d%0d_gnt", D),   68'(o_gnt[g]),   68'(m_gnt()));
            check($sformatf("d%0d_req", D),   68'(o_req[g]),   68'(m_req()));
            check($sformatf("d%0d_wen", D),   68'(o_wen[g]),   68'(0));
            check($sformatf("d%0d_count", D), 68'(o_count[g]), 68'(q.size()));
            check($sformatf("d%0d_empty", D), 68'(o_empty[g]), 68'(q.size() == 0));
            check($sformatf("d%0d_full", D),  68'(o_full[g]),  68'(q.size() == D));
            check($sformatf("d%0d_af", D),    68'(o_af[g]),    68'(q.size() >= D - AFM));
            check($sformatf("d%0d_err", D),   68'(o_err[g]),   68'(err));
            check($sformatf("d%0d_state", D), 68'(o_drain[g]), 68'(drain));
            if (q.size() != 0) check($sformatf("d%0d_head", D), o_head[g], q[0]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic [31:0] a, input logic w);
        req  = 1'b1;
        add  = a;
        data = $urandom;
        be   = 4'($urandom);
        wen  = w;
    endtask

    task automatic idle();
        req = 1'b0;
        wen = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; batch_en = 1'b0; flush = 1'b0; req = 1'b0; wen = 1'b0;
        mst_gnt = 1'b0; thresh = 4'd0; add = '0; data = '0; be = '0;
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            check("rst_gnt",   68'(o_gnt[i]),   68'(1));
            check("rst_req",   68'(o_req[i]),   68'(0));
            check("rst_count", 68'(o_count[i]), 68'(0));
            check("rst_empty", 68'(o_empty[i]), 68'(1));
            check("rst_err",   68'(o_err[i]),   68'(0));
            check("rst_head",  o_head[i],       68'(0));
        end
        rst = 1'b0;

        // Plain mode fill with grant held low, then drain in order.
        for (int i = 0; i < 8; i++) begin
            set_push(32'h100 + 4 * i, 1'b0);
            tick();
            check("t1_count", 68'(o_count[0]), 68'(i + 1));
            check("t1_af",    68'(o_af[0]),    68'((i + 1) >= 6));
        end
        check("t1_full", 68'(o_full[0]), 68'(1));
        check("t1_gnt",  68'(o_gnt[0]),  68'(0));
        set_push(32'h200, 1'b0);
        tick();
        check("t1_no_push", 68'(o_count[0]), 68'(8));
        idle();
        mst_gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t1_req",   68'(o_req[0]),          68'(1));
            check("t1_order", 68'(o_head[0][31:0]),   68'(32'h100 + 4 * i));
            check("t1_wen",   68'(o_wen[0]),          68'(0));
            tick();
        end
        check("t1_empty", 68'(o_empty[0]), 68'(1));

        // Depth-5 wrap with continuous push/pop.
        check("t2_req0", 68'(o_req[1]), 68'(0));
        for (int i = 0; i < 12; i++) begin
            set_push(32'h300 + 4 * i, 1'b0);
            tick();
            check("t2_req",   68'(o_req[1]),        68'(1));
            check("t2_count", 68'(o_count[1]),      68'(1));
            check("t2_order", 68'(o_head[1][31:0]), 68'(32'h300 + 4 * i));
        end
        idle();
        tick();
        check("t2_empty", 68'(o_empty[1]), 68'(1));

        // Batch release on threshold 4.
        batch_en = 1'b1; thresh = 4'd4;
        for (int i = 0; i < 3; i++) begin
            set_push(32'h400 + 4 * i, 1'b0);
            tick();
        end
        idle();
        repeat (3) begin
            tick();
            check("t3_hold", 68'(o_req[0]), 68'(0));
        end
        set_push(32'h40C, 1'b0);
        tick();
        idle();
        check("t3_cnt4",    68'(o_count[0]), 68'(4));
        check("t3_req_lag", 68'(o_req[0]),   68'(0));
        tick();
        check("t3_drain", 68'(o_drain[0]), 68'(1));
        for (int i = 0; i < 4; i++) begin
            check("t3_req",   68'(o_req[0]),        68'(1));
            check("t3_order", 68'(o_head[0][31:0]), 68'(32'h400 + 4 * i));
            tick();
        end
        check("t3_count", 68'(o_count[0]), 68'(0));
        check("t3_accum", 68'(o_drain[0]), 68'(0));
        check("t3_req_end", 68'(o_req[0]), 68'(0));

        // Flush releases a partial batch; flush on empty does nothing.
        thresh = 4'd6;
        set_push(32'h500, 1'b0); tick();
        set_push(32'h504, 1'b0); tick();
        idle();
        repeat (2) begin
            tick();
            check("t4_hold", 68'(o_req[0]), 68'(0));
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_req", 68'(o_req[0]),        68'(1));
        check("t4_h0",  68'(o_head[0][31:0]), 68'(32'h500));
        tick();
        check("t4_h1",  68'(o_head[0][31:0]), 68'(32'h504));
        tick();
        check("t4_count", 68'(o_count[0]), 68'(0));
        check("t4_req_end", 68'(o_req[0]), 68'(0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_flush_empty", 68'(o_drain[0]), 68'(0));
        tick();
        check("t4_no_req", 68'(o_req[0]), 68'(0));

        // Sticky wen error, then clear beats a simultaneous push.
        batch_en = 1'b0;
        set_push(32'h600, 1'b1);
        tick();
        idle();
        check("t5_err",  68'(o_err[0]),         68'(1));
        check("t5_wen",  68'(o_wen[0]),         68'(0));
        check("t5_head", 68'(o_head[0][31:0]),  68'(32'h600));
        tick();
        check("t5_popped", 68'(o_count[0]), 68'(0));
        check("t5_sticky", 68'(o_err[0]),   68'(1));
        mst_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(32'h610 + 4 * i, 1'b0);
            tick();
        end
        check("t5_cnt3", 68'(o_count[0]), 68'(3));
        clear = 1'b1;
        set_push(32'h700, 1'b0);
        tick();
        clear = 1'b0;
        idle();
        check("t5_clr_count", 68'(o_count[0]), 68'(0));
        check("t5_clr_err",   68'(o_err[0]),   68'(0));
        check("t5_clr_empty", 68'(o_empty[0]), 68'(1));
        tick();
        check("t5_discard", 68'(o_count[0]), 68'(0));

        // Asynchronous reset in the middle of a stalled drain.
        batch_en = 1'b1; thresh = 4'd4;
        for (int i = 0; i < 4; i++) begin
            set_push(32'h800 + 4 * i, 1'b0);
            tick();
        end
        idle();
        tick();
        tick();
        check("t6_req",   68'(o_req[0]),   68'(1));
        check("t6_drain", 68'(o_drain[0]), 68'(1));
        check("t6_count", 68'(o_count[0]), 68'(4));
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_req",   68'(o_req[0]),   68'(0));
        check("t6_rst_count", 68'(o_count[0]), 68'(0));
        check("t6_rst_gnt",   68'(o_gnt[0]),   68'(1));
        check("t6_rst_empty", 68'(o_empty[0]), 68'(1));
        check("t6_rst_head",  o_head[0],       68'(0));
        tick();
        rst = 1'b0;
        batch_en = 1'b0;

        // Randomised traffic across both modes.
        for (int c = 0; c < 3000; c++) begin
            req     = ($urandom_range(0, 9) < 6);
            add     = $urandom;
            data    = $urandom;
            be      = 4'($urandom);
            wen     = ($urandom_range(0, 19) == 0);
            mst_gnt = 1'($urandom_range(0, 1));
            flush   = ($urandom_range(0, 19) == 0);
            clear   = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 39) == 0) batch_en = ~batch_en;
            if ($urandom_range(0, 29) == 0) thresh = 4'($urandom);
            tick();
        end
        idle();
        clear = 1'b0; flush = 1'b0; mst_gnt = 1'b1; batch_en = 1'b0;
        repeat (12) tick();
        check("end_empty0", 68'(o_empty[0]), 68'(1));
        check("end_empty1", 68'(o_empty[1]), 68'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
